// File: rtl/tlp_tx_framer_if.sv
// ---------------------------------------------------------------------------
// tlp_tx_framer_if
//   Bundles the three streams around the TLP transmit framer:
//     request descriptor : req_valid/req_ready, req_hdr[127:0], req_4dw, req_len
//     payload DW stream  : pl_valid/pl_ready, pl_data[31:0]
//     framed TLP output  : o_valid/i_ready, o_data[31:0], o_sop, o_eop
//   slave  : the framer side (consumes req/pl, produces the TLP stream)
//   master : the environment side (request generator plus downstream sink)
// ---------------------------------------------------------------------------
interface tlp_tx_framer_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic             req_valid;
  logic             req_ready;
  logic [127:0]     req_hdr;
  logic             req_4dw;
  logic [LEN_W-1:0] req_len;

  logic             pl_valid;
  logic             pl_ready;
  logic [31:0]      pl_data;

  logic             o_valid;
  logic             i_ready;
  logic [31:0]      o_data;
  logic             o_sop;
  logic             o_eop;

  modport master (
    output req_valid, req_hdr, req_4dw, req_len, pl_valid, pl_data, i_ready,
    input  req_ready, pl_ready, o_valid, o_data, o_sop, o_eop
  );

  modport slave (
    input  req_valid, req_hdr, req_4dw, req_len, pl_valid, pl_data, i_ready,
    output req_ready, pl_ready, o_valid, o_data, o_sop, o_eop
  );
endinterface

// File: rtl/tlp_tx_framer.sv
// ---------------------------------------------------------------------------
// tlp_tx_framer
//   Transmit-side TLP framer. Accepts one descriptor (3DW/4DW header plus a
//   payload length) and then a payload DW stream, and emits the TLP as a
//   DW-serial registered stream with sop/eop markers.
//   The output register loads only when it is empty or being consumed
//   (load = !o_valid || i_ready) and holds otherwise, so a stall freezes
//   the outputs and blocks every upstream handshake.
// Ports
//   clk        clock
//   rst        asynchronous, active-low reset
//   bus        tlp_tx_framer_if.slave (request, payload and output streams)
//   tlp_count  number of TLPs whose eop beat was consumed, wraps at 16 bits
// ---------------------------------------------------------------------------
module tlp_tx_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  tlp_tx_framer_if.slave     bus,
  output logic [15:0]        tlp_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_t;

  state_t                state_q, state_d;

  logic [127:0]          hdr_q, hdr_d;
  logic                  is4_q, is4_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [1:0]            idx_q, idx_d;
  logic [LEN_W-1:0]      rem_q, rem_d;

  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q,  o_data_d;
  logic                  o_sop_q,   o_sop_d;
  logic                  o_eop_q,   o_eop_d;
  logic [15:0]           tlp_count_q;

  logic                  load;
  logic                  req_ready;
  logic                  pl_ready;
  logic [1:0]            hdr_last;
  logic                  hdr_done;
  logic [31:0]           hdr_dw;
  logic [LEN_W-1:0]      len_clamped;

  assign load        = !o_valid_q || bus.i_ready;
  assign hdr_last    = is4_q ? 2'd3 : 2'd2;
  assign hdr_done    = (idx_q == hdr_last);
  assign len_clamped = (bus.req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.req_len;

  // Header DW selected by idx; DW0 sits in the top 32 bits.
  always_comb begin
    unique case (idx_q)
      2'd0:    hdr_dw = hdr_q[127:96];
      2'd1:    hdr_dw = hdr_q[95:64];
      2'd2:    hdr_dw = hdr_q[63:32];
      default: hdr_dw = hdr_q[31:0];
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (load && bus.req_valid) state_d = HDR;
      HDR:  if (load && hdr_done)      state_d = (len_q == '0) ? IDLE : PAY;
      PAY:  if (load && bus.pl_valid && rem_q == LEN_W'(1)) state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath logic
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    req_ready = 1'b0;
    pl_ready  = 1'b0;
    hdr_d     = hdr_q;
    is4_d     = is4_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_sop_d   = o_sop_q;
    o_eop_d   = o_eop_q;

    unique case (state_q)
      IDLE: begin
        req_ready = load;
        if (load) begin
          if (bus.req_valid) begin
            hdr_d     = bus.req_hdr;
            is4_d     = bus.req_4dw;
            len_d     = len_clamped;
            idx_d     = 2'd1;
            o_valid_d = 1'b1;
            o_data_d  = bus.req_hdr[127:96];
            o_sop_d   = 1'b1;
            o_eop_d   = 1'b0;
          end else begin
            o_valid_d = 1'b0;
            o_sop_d   = 1'b0;
            o_eop_d   = 1'b0;
          end
        end
      end

      HDR: begin
        if (load) begin
          o_valid_d = 1'b1;
          o_data_d  = hdr_dw;
          o_sop_d   = 1'b0;
          // With no payload the last header DW closes the TLP.
          o_eop_d   = hdr_done && (len_q == '0);
          idx_d     = idx_q + 2'd1;
          if (hdr_done) rem_d = len_q;
        end
      end

      PAY: begin
        pl_ready = load;
        if (load) begin
          o_sop_d = 1'b0;
          if (bus.pl_valid) begin
            o_valid_d = 1'b1;
            o_data_d  = bus.pl_data;
            o_eop_d   = (rem_q == LEN_W'(1));
            rem_d     = rem_q - LEN_W'(1);
          end else begin
            // Payload not ready yet: emit a bubble, the TLP resumes later.
            o_valid_d = 1'b0;
            o_eop_d   = 1'b0;
          end
        end
      end

      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  // NOTE: the latched header is a plain register, not a RAM, so it is cleared
  // with the rest of the state and no stale header survives a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_q     <= '0;
      is4_q     <= 1'b0;
      len_q     <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_sop_q   <= 1'b0;
      o_eop_q   <= 1'b0;
    end else begin
      hdr_q     <= hdr_d;
      is4_q     <= is4_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_sop_q   <= o_sop_d;
      o_eop_q   <= o_eop_d;
    end
  end

  // A TLP counts once its eop beat is actually consumed downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  tlp_count_q <= '0;
    else if (o_valid_q && bus.i_ready && o_eop_q) tlp_count_q <= tlp_count_q + 16'd1;
  end

  assign bus.req_ready = req_ready;
  assign bus.pl_ready  = pl_ready;
  assign bus.o_valid   = o_valid_q;
  assign bus.o_data    = o_data_q;
  assign bus.o_sop     = o_sop_q;
  assign bus.o_eop     = o_eop_q;
  assign tlp_count     = tlp_count_q;

endmodule
